// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: address map, DMA states and decode helper shared by the CPU bus responder
package cpu_bus_pkg;
    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] RAM_MASK = 16'hE000;
    localparam logic [15:0] PPU_BASE = 16'h2000;
    localparam logic [15:0] PPU_MASK = 16'hE000;
    localparam logic [15:0] DMA_REG  = 16'h4014;
    localparam logic [15:0] PAD1     = 16'h4016;
    localparam logic [15:0] PRG_BASE = 16'h8000;
    localparam logic [15:0] PRG_MASK = 16'h8000;
    localparam logic [2:0]  PPU_OAMDATA = 3'd4;

    typedef enum logic [2:0] {IDLE, WAIT, ALIGN, RD, WR} dma_state_t;

    function automatic logic in_region(input logic [15:0] addr, input logic [15:0] base, input logic [15:0] mask);
        return (addr & mask) == base;
    endfunction
endpackage

// File: rtl/oam_dma_engine.sv
// oam_dma_engine: copies one 256-byte CPU page into PPU OAMDATA, stalling the CPU meanwhile
module oam_dma_engine
    import cpu_bus_pkg::*;
(
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  page_in,
    input  logic        parity,
    input  logic [7:0]  bus_rdata,
    output logic        active,
    output logic        wr_slot,
    output logic        rdy,
    output logic [15:0] addr,
    output logic [7:0]  dma_data
);
    dma_state_t state, state_nx;
    logic [7:0] page, idx;

    // state register; rdy is registered so it drops the cycle after the $4014 write
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            state <= IDLE;
            rdy   <= 1'b1;
        end else begin
            state <= state_nx;
            rdy   <= state_nx == IDLE;
        end
    end

    // page latch, byte index and read-slot data capture
    always_ff @(posedge clk_ph1) begin
        if (start && state == IDLE) page <= page_in;
        if (state == RD) dma_data <= bus_rdata;
        idx <= (!rst || state == IDLE) ? 8'd0 : (state == WR) ? idx + 8'd1 : idx;
    end

    // next state and bus address; the WR slot always targets OAMDATA
    always_comb begin
        state_nx = state;
        active   = 1'b0;
        wr_slot  = 1'b0;
        addr     = {page, idx};
        case (state)
            IDLE:  state_nx = start ? WAIT : IDLE;
            WAIT:  state_nx = parity ? ALIGN : RD;
            ALIGN: state_nx = RD;
            RD: begin
                state_nx = WR;
                active   = 1'b1;
            end
            WR: begin
                state_nx = (idx == 8'hFF) ? IDLE : RD;
                active   = 1'b1;
                wr_slot  = 1'b1;
                addr     = PPU_BASE | {13'd0, PPU_OAMDATA};
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: CPU bus decode for work RAM, PRG ROM, PPU registers, $4016 pad port and $4014 OAM DMA
module cpu_bus_responder
    import cpu_bus_pkg::*;
#(
    parameter int PRG_ADDR_W = 15,
    parameter int RAM_ADDR_W = 11
) (
    input  logic                  clk_ph1,
    input  logic                  rst,
    input  logic [15:0]           cpu_addr,
    input  logic                  cpu_rw,
    input  logic [7:0]            cpu_wdata,
    output logic [7:0]            cpu_rdata,
    output logic                  cpu_rdy,
    output logic [PRG_ADDR_W-1:0] prg_addr,
    input  logic [7:0]            prg_rdata,
    output logic                  ppu_cs,
    output logic [2:0]            ppu_reg,
    output logic                  ppu_rw,
    output logic [7:0]            ppu_wdata,
    input  logic [7:0]            ppu_rdata,
    input  logic [7:0]            pad1_buttons
);
    logic [7:0]  ram [0:(1<<RAM_ADDR_W)-1];
    logic [15:0] ea, dma_addr;
    logic [7:0]  dma_data, shift, pad_rdata;
    logic        dma_active, dma_wr, parity, strobe;
    logic        in_ram, in_ppu, in_prg, is_pad;
    logic        cpu_acc, cpu_wr, cpu_rd, dma_start;

    // DMA owns the address bus during its read/write slots
    assign ea     = dma_active ? dma_addr : cpu_addr;
    assign in_ram = in_region(ea, RAM_BASE, RAM_MASK);
    assign in_ppu = in_region(ea, PPU_BASE, PPU_MASK);
    assign in_prg = in_region(ea, PRG_BASE, PRG_MASK);
    assign is_pad = ea == PAD1;

    // a stalled CPU (or one held in reset) has no side effects on the bus
    assign cpu_acc   = rst && cpu_rdy;
    assign cpu_wr    = cpu_acc && !cpu_rw;
    assign cpu_rd    = cpu_acc && cpu_rw;
    assign dma_start = cpu_wr && ea == DMA_REG;

    assign pad_rdata = {7'b0100000, strobe ? pad1_buttons[0] : shift[0]};
    assign cpu_rdata = in_ram ? ram[ea[RAM_ADDR_W-1:0]] :
                       in_ppu ? ppu_rdata :
                       in_prg ? prg_rdata :
                       is_pad ? pad_rdata : 8'h00;

    assign prg_addr  = ea[PRG_ADDR_W-1:0];
    assign ppu_cs    = rst && in_ppu && (cpu_acc || dma_wr);
    assign ppu_reg   = ea[2:0];
    assign ppu_rw    = dma_wr ? 1'b0 : cpu_rw;
    assign ppu_wdata = dma_wr ? dma_data : cpu_wdata;

    // cycle parity decides whether the DMA needs an alignment cycle
    always_ff @(posedge clk_ph1) begin
        parity <= rst ? !parity : 1'b0;
    end

    // controller strobe latch and serial shift register
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            strobe <= 1'b0;
            shift  <= 8'h00;
        end else begin
            if (cpu_wr && is_pad) strobe <= cpu_wdata[0];
            if (strobe) shift <= pad1_buttons;
            else if (cpu_rd && is_pad) shift <= {1'b1, shift[7:1]};
        end
    end

    // work RAM write port; contents survive reset
    always_ff @(posedge clk_ph1) begin
        if (cpu_wr && in_ram) ram[ea[RAM_ADDR_W-1:0]] <= cpu_wdata;
    end

    oam_dma_engine u_dma (
        .clk_ph1   (clk_ph1),
        .rst       (rst),
        .start     (dma_start),
        .page_in   (cpu_wdata),
        .parity    (parity),
        .bus_rdata (cpu_rdata),
        .active    (dma_active),
        .wr_slot   (dma_wr),
        .rdy       (cpu_rdy),
        .addr      (dma_addr),
        .dma_data  (dma_data)
    );
endmodule

// File: tb/tb_cpu_bus_responder.sv
// tb_cpu_bus_responder: directed checks of decode, RAM/PPU/PRG mirroring, pad port and OAM DMA
module tb_cpu_bus_responder;
    import cpu_bus_pkg::*;

    logic        clk_ph1 = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] cpu_addr = 16'h5000;
    logic        cpu_rw = 1'b1;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdy;
    logic [13:0] prg_addr;
    logic [7:0]  prg_rdata;
    logic        ppu_cs;
    logic [2:0]  ppu_reg;
    logic        ppu_rw;
    logic [7:0]  ppu_wdata;
    logic [7:0]  ppu_rdata = 8'h5C;
    logic [7:0]  pad1_buttons = 8'h00;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int stall, nwr, cs_seen;
    logic [7:0] pad_exp [0:8];

    cpu_bus_responder #(.PRG_ADDR_W(14), .RAM_ADDR_W(11)) dut (
        .clk_ph1      (clk_ph1),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_rw       (cpu_rw),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_rdy      (cpu_rdy),
        .prg_addr     (prg_addr),
        .prg_rdata    (prg_rdata),
        .ppu_cs       (ppu_cs),
        .ppu_reg      (ppu_reg),
        .ppu_rw       (ppu_rw),
        .ppu_wdata    (ppu_wdata),
        .ppu_rdata    (ppu_rdata),
        .pad1_buttons (pad1_buttons)
    );

    // 16 KB ROM: only 0x0123 holds the marker byte
    assign prg_rdata = (prg_addr == 14'h0123) ? 8'h7E : 8'hEE;

    always #5 clk_ph1 = ~clk_ph1;

    // cycles since reset release; bit 0 is the expected bus parity
    always @(posedge clk_ph1) cyc <= rst ? cyc + 1 : 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        @(negedge clk_ph1);
        cpu_addr = a;
        cpu_rw = rw;
        cpu_wdata = d;
        #1;
    endtask

    // write $4014=02 in a cycle of parity p, then follow the stall; stop early after stop_after WR slots
    task automatic run_dma(input bit p, input int stop_after, output int st, output int nw);
        st = 0;
        nw = 0;
        @(negedge clk_ph1);
        while (cyc[0] != p) @(negedge clk_ph1);
        cpu_addr = 16'h4014;
        cpu_rw = 1'b0;
        cpu_wdata = 8'h02;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk_ph1);
            if (cpu_rdy) break;
            cpu_addr = (k % 2 == 0) ? 16'h0005 : 16'h4014;
            cpu_rw = 1'b0;
            cpu_wdata = 8'h33;
            #1;
            st++;
            if (ppu_cs) begin
                check("dma_wr_slot", {ppu_reg, ppu_rw, ppu_wdata}, {3'd4, 1'b0, nw[7:0]});
                nw++;
                if (nw == stop_after) break;
            end
        end
        cpu_addr = 16'h5000;
        cpu_rw = 1'b1;
    endtask

    initial begin
        pad_exp = '{8'h41, 8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h41, 8'h41};
        repeat (3) drive(16'h5000, 1'b1, 8'h00);
        check("rst_rdy", cpu_rdy, 1);
        check("rst_ppu_cs", ppu_cs, 0);
        check("rst_state", dut.u_dma.state, IDLE);
        drive(16'h5000, 1'b1, 8'h00);
        rst = 1'b1;
        drive(16'h4016, 1'b1, 8'h00);
        check("rst_pad_shift", cpu_rdata, 8'h40);

        drive(16'h0006, 1'b0, 8'h3C);
        drive(16'h0005, 1'b0, 8'hA5);
        drive(16'h0805, 1'b1, 8'h00);
        check("ram_mirror_0805", cpu_rdata, 8'hA5);
        drive(16'h1805, 1'b1, 8'h00);
        check("ram_mirror_1805", cpu_rdata, 8'hA5);
        drive(16'h0006, 1'b1, 8'h00);
        check("ram_neighbour", cpu_rdata, 8'h3C);

        drive(16'h3FFA, 1'b1, 8'h00);
        check("ppu_rd_select", {ppu_cs, ppu_reg, ppu_rw}, {1'b1, 3'd2, 1'b1});
        check("ppu_rd_data", cpu_rdata, 8'h5C);
        drive(16'h2001, 1'b0, 8'h1E);
        check("ppu_wr", {ppu_cs, ppu_reg, ppu_rw, ppu_wdata}, {1'b1, 3'd1, 1'b0, 8'h1E});
        drive(16'h4000, 1'b1, 8'h00);
        check("apu_cs", ppu_cs, 0);
        check("apu_rdata", cpu_rdata, 8'h00);

        drive(16'h8123, 1'b1, 8'h00);
        check("prg_8123", {prg_addr, cpu_rdata}, {14'h0123, 8'h7E});
        drive(16'hC123, 1'b1, 8'h00);
        check("prg_c123", {prg_addr, cpu_rdata}, {14'h0123, 8'h7E});
        drive(16'h4014, 1'b1, 8'h00);
        check("dma_reg_read", cpu_rdata, 8'h00);
        drive(16'h6000, 1'b1, 8'h00);
        check("unmapped_read", cpu_rdata, 8'h00);

        pad1_buttons = 8'b1001_0011;
        drive(16'h4016, 1'b0, 8'h01);
        pad1_buttons = 8'h02;
        drive(16'h4016, 1'b1, 8'h00);
        check("pad_strobe_read", cpu_rdata, 8'h40);
        pad1_buttons = 8'b1001_0011;
        drive(16'h4016, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            drive(16'h4016, 1'b1, 8'h00);
            check($sformatf("pad_read%0d", i), cpu_rdata, pad_exp[i]);
        end

        for (int i = 0; i < 256; i++) drive(16'h0200 + 16'(i), 1'b0, 8'(i));
        run_dma(1'b1, 0, stall, nwr);
        check("dma_stall_even", stall, 513);
        check("dma_writes_even", nwr, 256);
        run_dma(1'b0, 0, stall, nwr);
        check("dma_stall_odd", stall, 514);
        check("dma_writes_odd", nwr, 256);
        drive(16'h0005, 1'b1, 8'h00);
        check("stalled_write_ignored", cpu_rdata, 8'hA5);

        run_dma(1'b1, 100, stall, nwr);
        check("abort_slots", nwr, 100);
        cs_seen = 0;
        repeat (2) begin
            @(negedge clk_ph1);
            rst = 1'b0;
            #1;
            cs_seen += int'(ppu_cs);
        end
        @(negedge clk_ph1);
        rst = 1'b1;
        #1;
        check("abort_rdy", cpu_rdy, 1);
        check("abort_state", dut.u_dma.state, IDLE);
        repeat (20) begin
            drive(16'h5000, 1'b1, 8'h00);
            cs_seen += int'(ppu_cs);
        end
        check("abort_no_cs", cs_seen, 0);
        run_dma(1'b1, 0, stall, nwr);
        check("restart_stall", stall, 513);
        check("restart_writes", nwr, 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
